// File: rtl/fetch_if.sv
// Fetch-stage bundle: imem request/response, control-unit feedback and presented instruction.
// Carries misalign_err only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_if;
  logic        PCSrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] retired;
  logic        imem_timeout;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  modport master (
    input  PCSrc, ImmOp, stall, imem_valid, imem_rdata,
    output imem_req, imem_addr, instr, instr_valid, PC, retired, imem_timeout
`ifdef FETCH_MISALIGN_TRAP_EN
    , output misalign_err
`endif
  );

  modport slave (
    output PCSrc, ImmOp, stall, imem_valid, imem_rdata,
    input  imem_req, imem_addr, instr, instr_valid, PC, retired, imem_timeout
`ifdef FETCH_MISALIGN_TRAP_EN
    , input misalign_err
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, variable-latency imem handshake, next-PC from PCSrc/ImmOp.
// Optional FETCH_MISALIGN_TRAP_EN: halt with misalign_err instead of forcing next-PC low bits to zero.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MAX_WAIT     = 16
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {START, FETCH, WAIT, ISSUE, HALT} state_t;
`else
  typedef enum logic [2:0] {START, FETCH, WAIT, ISSUE} state_t;
`endif

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);

  state_t             state;
  logic        [31:0] pc;
  logic        [31:0] instr;
  logic               instr_valid;
  logic               imem_req;
  logic        [31:0] retired;
  logic               imem_timeout;
  logic        [7:0]  wait_cnt;
  logic        [31:0] npc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic               misalign_err;
`endif

  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic take,
                                          input logic signed [31:0] imm);
    return take ? (cur + $unsigned(imm)) : (cur + 32'd4);
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] x);
    return {x[31:2], 2'b00};
  endfunction

  assign npc = next_pc(pc, bus.PCSrc, bus.ImmOp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= START;
      pc           <= RESET_VECTOR;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      retired      <= 32'd0;
      imem_timeout <= 1'b0;
      wait_cnt     <= 8'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      case (state)
        // START swallows any response still in flight from before reset
        START: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          wait_cnt <= 8'd0;
          if (bus.imem_valid) begin
            instr       <= bus.imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_valid) begin
            instr       <= bus.imem_rdata;
            wait_cnt    <= 8'd0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end else begin
            if (wait_cnt != MAX_WAIT_C) wait_cnt <= wait_cnt + 8'd1;
            if (({1'b0, wait_cnt} + 9'd1) >= {1'b0, MAX_WAIT_C}) imem_timeout <= 1'b1;
          end
        end
        ISSUE: begin
          if (!bus.stall) begin
            retired <= retired + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (npc[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
              instr_valid  <= 1'b0;
              state        <= HALT;
            end else begin
              pc          <= npc;
              imem_req    <= 1'b1;
              instr_valid <= 1'b0;
              state       <= FETCH;
            end
`else
            pc          <= align_pc(npc);
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= FETCH;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif
        default: begin
          state       <= START;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.imem_addr    = pc;
  assign bus.instr        = instr;
  assign bus.instr_valid  = instr_valid;
  assign bus.PC           = pc;
  assign bus.retired      = retired;
  assign bus.imem_timeout = imem_timeout;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misalign_err = misalign_err;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (MAX_WAIT=2): reset, zero-wait fetch, branches, wait states,
// timeout, stall, reset mid-request and next-PC misalignment.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  fetch_if bus ();

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .MAX_WAIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch0(input logic [31:0] d);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = d;
    step();
    bus.imem_valid = 1'b0;
  endtask

  task automatic issue(input logic s, input logic [31:0] imm);
    bus.PCSrc = s;
    bus.ImmOp = imm;
    step();
    bus.PCSrc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PCSrc = 1'b0;
    bus.ImmOp = 32'd0;
    bus.stall = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'd0;

    // reset state
    step(); step();
    chk("rst_req",     {31'd0, bus.imem_req}, 32'd0);
    chk("rst_pc",      bus.PC, 32'h0);
    chk("rst_instr",   bus.instr, 32'h0000_0013);
    chk("rst_ivalid",  {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_tmo",     {31'd0, bus.imem_timeout}, 32'd0);

    // zero-wait fetch; valid held through START must be ignored there
    rst = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    step();
    chk("zw_req",    {31'd0, bus.imem_req}, 32'd1);
    chk("zw_addr",   bus.imem_addr, 32'h0);
    chk("zw_ivalid0", {31'd0, bus.instr_valid}, 32'd0);
    step();
    chk("zw_ivalid", {31'd0, bus.instr_valid}, 32'd1);
    chk("zw_instr",  bus.instr, 32'h0050_0093);
    chk("zw_req0",   {31'd0, bus.imem_req}, 32'd0);
    bus.imem_valid = 1'b0;
    issue(1'b0, 32'd0);
    chk("seq_pc",      bus.PC, 32'h4);
    chk("seq_retired", bus.retired, 32'd1);
    chk("seq_ivalid",  {31'd0, bus.instr_valid}, 32'd0);

    // branches and wrap
    fetch0(32'h00C0_0113);
    issue(1'b1, 32'h0000_000C);
    chk("br_to10", bus.PC, 32'h10);
    fetch0(32'h00C0_0113);
    issue(1'b1, 32'hFFFF_FFF8);
    chk("br_neg", bus.PC, 32'h08);
    fetch0(32'h00C0_0113);
    issue(1'b1, 32'hFFFF_FFF4);
    chk("br_top", bus.PC, 32'hFFFF_FFFC);
    fetch0(32'h00C0_0113);
    issue(1'b0, 32'd0);
    chk("pc_wrap", bus.PC, 32'h0);
    chk("wrap_retired", bus.retired, 32'd5);

    // latency 3: FETCH + two WAIT cycles
    step();
    chk("l3_req1",  {31'd0, bus.imem_req}, 32'd1);
    chk("l3_addr1", bus.imem_addr, 32'h0);
    step();
    chk("l3_req2",  {31'd0, bus.imem_req}, 32'd1);
    chk("l3_addr2", bus.imem_addr, 32'h0);
    fetch0(32'h00A0_0113);
    chk("l3_instr",  bus.instr, 32'h00A0_0113);
    chk("l3_ivalid", {31'd0, bus.instr_valid}, 32'd1);
    chk("l3_tmo",    {31'd0, bus.imem_timeout}, 32'd0);

    // stall holds everything; PCSrc toggles are ignored
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.PCSrc = i[0];
      bus.ImmOp = 32'h40;
      step();
      chk("st_ivalid",  {31'd0, bus.instr_valid}, 32'd1);
      chk("st_pc",      bus.PC, 32'h0);
      chk("st_instr",   bus.instr, 32'h00A0_0113);
      chk("st_retired", bus.retired, 32'd5);
    end
    bus.stall = 1'b0;
    issue(1'b0, 32'd0);
    chk("st_adv_pc",      bus.PC, 32'h4);
    chk("st_adv_retired", bus.retired, 32'd6);

    // latency 5 with MAX_WAIT=2 -> sticky timeout
    step();
    chk("l5_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("l5_addr", bus.imem_addr, 32'h4);
    step();
    chk("l5_tmo0", {31'd0, bus.imem_timeout}, 32'd0);
    step();
    chk("l5_tmo1", {31'd0, bus.imem_timeout}, 32'd1);
    step();
    chk("l5_req3", {31'd0, bus.imem_req}, 32'd1);
    chk("l5_addr3", bus.imem_addr, 32'h4);
    fetch0(32'h0000_0033);
    chk("l5_instr",   bus.instr, 32'h0000_0033);
    chk("l5_tmo_rsp", {31'd0, bus.imem_timeout}, 32'd1);
    issue(1'b0, 32'd0);
    chk("l5_pc",      bus.PC, 32'h8);
    chk("l5_retired", bus.retired, 32'd7);
    chk("l5_tmo_hold", {31'd0, bus.imem_timeout}, 32'd1);

    // reset during WAIT; late response lands in START and is dropped
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_pc",      bus.PC, 32'h0);
    chk("rw_tmo",     {31'd0, bus.imem_timeout}, 32'd0);
    chk("rw_retired", bus.retired, 32'd0);
    chk("rw_req",     {31'd0, bus.imem_req}, 32'd0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_valid = 1'b0;
    chk("rw_instr",  bus.instr, 32'h0000_0013);
    chk("rw_ivalid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rw_req1",   {31'd0, bus.imem_req}, 32'd1);
    chk("rw_addr",   bus.imem_addr, 32'h0);
    step();
    fetch0(32'h0010_0093);
    chk("rw_instr2", bus.instr, 32'h0010_0093);

    // misaligned target
    issue(1'b1, 32'h20);
    chk("ma_pc20", bus.PC, 32'h20);
    fetch0(32'h0000_0013);
    issue(1'b1, 32'h6);
    chk("ma_retired", bus.retired, 32'd2);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_err",    {31'd0, bus.misalign_err}, 32'd1);
    chk("ma_pc",     bus.PC, 32'h20);
    chk("ma_req",    {31'd0, bus.imem_req}, 32'd0);
    chk("ma_ivalid", {31'd0, bus.instr_valid}, 32'd0);
    bus.imem_valid = 1'b1;
    step(); step(); step();
    bus.imem_valid = 1'b0;
    chk("ma_req_hold", {31'd0, bus.imem_req}, 32'd0);
    chk("ma_pc_hold",  bus.PC, 32'h20);
`else
    chk("ma_pc",  bus.PC, 32'h24);
    chk("ma_req", {31'd0, bus.imem_req}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
